bit_length_scan: RTL and testbench
==================================

# bit_length_scan

Parametrised multi-cycle bit-length / trailing-zero scanner for RSA operands. It latches a WIDTH-bit operand on `start` and examines STEP bits per clock. Mode 0 returns the bit length (index of the highest set bit + 1); mode 1 returns the trailing-zero count. It serves the modular-exponentiation control path, which uses it to size exponent loops and normalise moduli, and it supports a constant-time scan for side-channel resistance.

## Interface
- `WIDTH`, 64, operand width in bits; must be a multiple of STEP.
- `STEP`, 4, bits examined per clock cycle.
- `LW`, `$clog2(WIDTH+1)`, result width (derived; do not override).

- `clk` input 1: sole clock, rising edge.
- `rstn` input 1: synchronous, active-low reset.
- `start` input 1: request; sampled only when idle.
- `mode` input 1: 0 = bit length, 1 = trailing-zero count; latched with `start`.
- `num_in` input WIDTH: operand; latched with `start`.
- `busy` output 1: a scan is in progress.
- `done` output 1: single-cycle pulse; results valid.
- `len_out` output LW: result; held until the next accepted `start`.
- `zero_out` output 1: latched operand was all zeros; held like `len_out`.

## Operation
- FSM has two states: IDLE and SCAN. The chunk counter is `$clog2(WIDTH/STEP)` bits wide, and NCH = WIDTH/STEP.
- Accepting a request (IDLE and `start` = 1):
  - Latch `num_in` and `mode`.
  - Clear chunk counter and found flag.
  - Move to SCAN; `busy` goes to 1.
- SCAN, one chunk per edge:
  - Mode 0 scans chunks from the MSB chunk downward. Within a chunk, the highest set bit wins.
  - Mode 1 scans from the LSB chunk upward. Within a chunk, the lowest set bit wins.
  - The first chunk containing a one records the result. Later chunks never overwrite it.
- Mode 0 results: `len_out` = highest set bit index + 1. A zero operand gives `len_out` = 0.
- Mode 1 results: `len_out` = index of the lowest set bit. A zero operand gives `len_out` = WIDTH.
- `zero_out` = 1 exactly when the operand is zero.
- A scan terminates on the last chunk, or on the first hit when early exit is enabled (see Configuration).
- On the terminating edge:
  - `len_out` and `zero_out` are registered.
  - `done` goes to 1 and `busy` goes to 0.
  - FSM returns to IDLE.
- `start` while `busy` is ignored and has no side effect.
- `start` in the cycle `done` is high is accepted, because the FSM is already IDLE.
- A `num_in` change during SCAN has no effect.

## Timing
- Reset values, one edge after `rstn` = 0: `busy` = 0, `done` = 0, `len_out` = 0, `zero_out` = 0, FSM = IDLE, counter = 0.
- Reset mid-scan aborts the scan. No `done` is produced.
- Latency: with the accepting edge as edge 0, `done` is high after edge N, where N = number of chunks examined (1..NCH).
- `busy` is high after edges 0..N-1 and low after edge N.
- `done` is high for exactly one cycle.
- Throughput: one result per N+1 edges. Back-to-back operation needs `start` held through the `done` cycle.

## Configuration
- `BITLEN_EARLY_EXIT_EN` defined: the scan stops at the first chunk containing a one, so N varies with the data. A zero operand still takes N = NCH.
- `BITLEN_EARLY_EXIT_EN` undefined: every scan takes N = NCH regardless of data, which makes it constant-time. Results are identical in both builds.

## Test plan
All cases use defaults (WIDTH = 64, STEP = 4) unless stated.
- Low bit length: mode 0, `num_in` = 0x9 → `len_out` = 4, `zero_out` = 0. `done` after 16 edges in both builds.
- Top bit set: mode 0, `num_in` = 0x8000_0000_0000_0000 → `len_out` = 64. `done` after 1 edge with `BITLEN_EARLY_EXIT_EN`, after 16 without.
- Zero operand, both modes: `num_in` = 0 → mode 0 gives `len_out` = 0, `zero_out` = 1; mode 1 gives `len_out` = 64, `zero_out` = 1. Each takes 16 edges.
- Trailing zeros: mode 1, `num_in` = 0x100 → `len_out` = 8. `done` after 3 edges with early exit, 16 without.
- Handshake:
  - `start` pulsed at edges 2 and 5 of a scan → ignored.
  - `start` held in the `done` cycle → second scan accepted, `busy` high again the next cycle.
  - `rstn` = 0 at edge 6 of a scan → all outputs 0 next cycle, no `done` pulse.
- Wide configuration: WIDTH = 1024, STEP = 32, mode 0, `num_in` = 2^1023 + 1 → `len_out` = 1024. Mode 1 on the same operand → `len_out` = 0.

Source files
------------

// File: rtl/bit_length_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_length_scan_if
//  Description : Request/result bundle for bit_length_scan. The requester
//                drives start/mode/num_in. The scanner returns busy, the done
//                pulse and the held results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_length_scan_if #(
    parameter int WIDTH = 64
);
    localparam int LW = $clog2(WIDTH + 1);

    logic             start;
    logic             mode;
    logic [WIDTH-1:0] num_in;
    logic             busy;
    logic             done;
    logic [LW-1:0]    len_out;
    logic             zero_out;

    modport master (
        output start, mode, num_in,
        input  busy, done, len_out, zero_out
    );

    modport slave (
        input  start, mode, num_in,
        output busy, done, len_out, zero_out
    );
endinterface
`default_nettype wire

// File: rtl/bit_length_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bit_length_scan
//  Description : Multi-cycle bit-length (mode 0) / trailing-zero (mode 1)
//                scanner. It examines STEP bits per clock over a latched
//                WIDTH-bit operand.
//                Optional macro BITLEN_EARLY_EXIT_EN: stop at the first chunk
//                that contains a one. Without the macro every scan takes
//                WIDTH/STEP cycles, so the scan time does not depend on data.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_length_scan #(
    parameter int WIDTH = 64,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    bit_length_scan_if.slave bus
);
    localparam int LW  = $clog2(WIDTH + 1);
    localparam int NCH = WIDTH / STEP;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);
    localparam logic [LW-1:0] WIDTH_LEN  = LW'(WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             found_q, found_d;
    logic [LW-1:0]    res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LW-1:0]    len_out_q, len_out_d;
    logic             zero_out_q, zero_out_d;

    logic [CW-1:0]    chunk_idx;
    logic [STEP-1:0]  chunk;
    logic             hit;
    int               bit_pos;
    logic [LW-1:0]    hit_val;

    // Select the current chunk and locate its winning bit. Mode 0 walks down
    // from the MSB chunk and takes the highest set bit. Mode 1 walks up from
    // the LSB chunk and takes the lowest set bit.
    always_comb begin
        chunk_idx = mode_q ? cnt_q : (LAST_CHUNK - cnt_q);
        chunk     = num_q[int'(chunk_idx) * STEP +: STEP];
        hit       = |chunk;
        bit_pos   = 0;
        if (mode_q) begin
            for (int i = STEP - 1; i >= 0; i--) begin
                if (chunk[i]) bit_pos = i;
            end
        end else begin
            for (int i = 0; i < STEP; i++) begin
                if (chunk[i]) bit_pos = i;
            end
        end
        // The bit length is the index plus one. The trailing-zero count is the index itself.
        hit_val = LW'(int'(chunk_idx) * STEP + bit_pos + (mode_q ? 0 : 1));
    end

    logic          found_any;
    logic [LW-1:0] res_now;
    logic          last;

    // Next-state logic: accept a request when idle, then advance one chunk
    // per edge until the terminating chunk.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        found_d    = found_q;
        res_d      = res_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        len_out_d  = len_out_q;
        zero_out_d = zero_out_q;

        found_any  = found_q | hit;
        res_now    = found_q ? res_q : hit_val;
`ifdef BITLEN_EARLY_EXIT_EN
        last       = (cnt_q == LAST_CHUNK) || found_any;
`else
        last       = (cnt_q == LAST_CHUNK);
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    num_d   = bus.num_in;
                    mode_d  = bus.mode;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Only the first chunk that contains a one records the result.
                if (!found_q && hit) begin
                    found_d = 1'b1;
                    res_d   = hit_val;
                end
                if (last) begin
                    len_out_d  = found_any ? res_now : (mode_q ? WIDTH_LEN : '0);
                    zero_out_d = ~found_any;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            num_q      <= '0;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            found_q    <= 1'b0;
            res_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_out_q  <= '0;
            zero_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            found_q    <= found_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_out_q  <= len_out_d;
            zero_out_q <= zero_out_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.len_out  = len_out_q;
    assign bus.zero_out = zero_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_length_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_length_scan
//  Description : Self-checking bench for bit_length_scan. It covers the
//                default 64/4 build and a wide 1024/32 instance. Results and
//                latency are compared with a bit-by-bit reference model.
//                Honours BITLEN_EARLY_EXIT_EN for the expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_length_scan;
    localparam int W  = 64;
    localparam int S  = 4;
    localparam int WW = 1024;
    localparam int WS = 32;
`ifdef BITLEN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    bit_length_scan_if #(.WIDTH(W))  nb ();
    bit_length_scan_if #(.WIDTH(WW)) wb ();

    bit_length_scan #(.WIDTH(W), .STEP(S)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (nb.slave)
    );

    bit_length_scan #(.WIDTH(WW), .STEP(WS)) u_dut_wide (
        .clk  (clk),
        .rstn (rstn),
        .bus  (wb.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: walk the bits directly.
    function automatic int ref_len(input bit m, input logic [1023:0] v, input int w);
        if (!m) begin
            for (int i = w - 1; i >= 0; i--) if (v[i]) return i + 1;
            return 0;
        end
        for (int i = 0; i < w; i++) if (v[i]) return i;
        return w;
    endfunction

    // Reference latency: the number of chunks visited before the scan stops.
    function automatic int ref_edges(input bit m, input logic [1023:0] v, input int w, input int s);
        int nch;
        int l;
        nch = w / s;
        l   = ref_len(m, v, w);
        if (!EARLY || v == '0) return nch;
        return m ? (l / s + 1) : (nch - (l - 1) / s);
    endfunction

    // Run one scan on the 64-bit instance. The call starts and ends #1 after
    // a rising edge. When junk is set, start is pulsed and the operand is
    // scrambled mid-scan.
    task automatic scan_n(input bit m, input logic [63:0] v, input bit junk);
        int edges;
        bit got;
        int exp_n;
        edges = 0;
        got   = 1'b0;
        exp_n = ref_edges(m, {960'b0, v}, W, S);
        nb.start = 1'b1; nb.mode = m; nb.num_in = v;
        @(posedge clk); #1;
        nb.start = 1'b0;
        check("busy_accept", 64'(nb.busy), 64'd1);
        check("done_accept", 64'(nb.done), 64'd0);
        while (!got && edges < 4 * W) begin
            @(posedge clk); #1;
            edges++;
            if (nb.done) got = 1'b1;
            else begin
                check("busy_mid", 64'(nb.busy), 64'd1);
                if (junk) begin
                    nb.start  = (edges == 2 || edges == 5);
                    nb.mode   = ~m;
                    nb.num_in = {$urandom, $urandom};
                end
            end
        end
        nb.start = 1'b0;
        check("latency", 64'(edges), 64'(exp_n));
        check("len_out", 64'(nb.len_out), 64'(ref_len(m, {960'b0, v}, W)));
        check("zero_out", 64'(nb.zero_out), 64'(v == 64'd0));
        check("busy_at_done", 64'(nb.busy), 64'd0);
    endtask

    // One idle cycle after done: the pulse ends and the results stay held.
    task automatic idle_n(input bit m, input logic [63:0] v);
        @(posedge clk); #1;
        check("done_pulse", 64'(nb.done), 64'd0);
        check("busy_idle", 64'(nb.busy), 64'd0);
        check("len_held", 64'(nb.len_out), 64'(ref_len(m, {960'b0, v}, W)));
    endtask

    task automatic scan_w(input bit m, input logic [1023:0] v);
        int edges;
        bit got;
        edges = 0;
        got   = 1'b0;
        wb.start = 1'b1; wb.mode = m; wb.num_in = v;
        @(posedge clk); #1;
        wb.start = 1'b0;
        check("w_busy_accept", 64'(wb.busy), 64'd1);
        while (!got && edges < 4 * (WW / WS)) begin
            @(posedge clk); #1;
            edges++;
            if (wb.done) got = 1'b1;
        end
        check("w_latency", 64'(edges), 64'(ref_edges(m, v, WW, WS)));
        check("w_len_out", 64'(wb.len_out), 64'(ref_len(m, v, WW)));
        check("w_zero_out", 64'(wb.zero_out), 64'(v == '0));
        @(posedge clk); #1;
        check("w_done_pulse", 64'(wb.done), 64'd0);
    endtask

    initial begin
        logic [63:0]   v;
        logic [1023:0] wv;
        bit            m;
        int            dones;

        nb.start = 1'b0; nb.mode = 1'b0; nb.num_in = '0;
        wb.start = 1'b0; wb.mode = 1'b0; wb.num_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(nb.busy), 64'd0);
        check("rst_done", 64'(nb.done), 64'd0);
        check("rst_len", 64'(nb.len_out), 64'd0);
        check("rst_zero", 64'(nb.zero_out), 64'd0);
        check("rst_w_busy", 64'(wb.busy), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        scan_n(1'b0, 64'h9, 1'b0);                  idle_n(1'b0, 64'h9);
        scan_n(1'b0, 64'h8000_0000_0000_0000, 1'b0); idle_n(1'b0, 64'h8000_0000_0000_0000);
        scan_n(1'b0, 64'h0, 1'b0);                  idle_n(1'b0, 64'h0);
        scan_n(1'b1, 64'h100, 1'b0);                idle_n(1'b1, 64'h100);
        scan_n(1'b0, 64'h0000_0001_0000_0000, 1'b1); idle_n(1'b0, 64'h0000_0001_0000_0000);

        // Back-to-back: the second request is raised in the done cycle.
        scan_n(1'b0, 64'hFF, 1'b0);
        scan_n(1'b1, 64'h30, 1'b0);
        idle_n(1'b1, 64'h30);

        // Leave len_out/zero_out non-zero before the reset test.
        scan_n(1'b1, 64'h0, 1'b0);                  idle_n(1'b1, 64'h0);

        // Reset at edge 6 of a scan aborts it.
        nb.start = 1'b1; nb.mode = 1'b0; nb.num_in = 64'h9;
        @(posedge clk); #1;
        nb.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 64'(nb.busy), 64'd0);
        check("abort_done", 64'(nb.done), 64'd0);
        check("abort_len", 64'(nb.len_out), 64'd0);
        check("abort_zero", 64'(nb.zero_out), 64'd0);
        rstn = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (nb.done || nb.busy) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        // Randomized operands and modes.
        for (int k = 0; k < 40; k++) begin
            v = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: v = v >> $urandom_range(0, 63);
                1: v = 64'd1 << $urandom_range(0, 63);
                2: v = v << $urandom_range(0, 63);
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) v = 64'd0;
            m = 1'($urandom_range(0, 1));
            scan_n(m, v, 1'($urandom_range(0, 1)));
            idle_n(m, v);
        end

        // Wide configuration.
        wv = '0; wv[1023] = 1'b1; wv[0] = 1'b1;
        scan_w(1'b0, wv);
        scan_w(1'b1, wv);
        wv = '0; wv[517] = 1'b1;
        scan_w(1'b1, wv);
        scan_w(1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
